// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86 icode constants, memory-pipe FSM states and icode decode helpers.
package y86_pkg;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  function automatic logic is_wr(input logic [3:0] ic);
    return ic == IRMMOVQ || ic == ICALL || ic == IPUSHQ;
  endfunction
  function automatic logic is_rd(input logic [3:0] ic);
    return ic == IMRMOVQ || ic == IRET || ic == IPOPQ;
  endfunction
  // ret and popq address the stack through valA; everything else uses valE
  function automatic logic uses_vala(input logic [3:0] ic);
    return ic == IRET || ic == IPOPQ;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x DATA_W storage, one synchronous write port, one asynchronous read port, no reset.
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
module dmem_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/data_memory_pipe.sv
// data_memory_pipe: Y86 memory stage with fixed-latency request/response handshake and range checking.
// Ports: clk, rst_n (async active-low); req_valid/req_ready request handshake with icode, valA, valE, valP;
//        resp_valid one-cycle response with valM and resp_error; err_clr clears sticky dmem_error.
module data_memory_pipe
  import y86_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        icode,
  input  logic [DATA_W-1:0] valA,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valP,
  output logic              resp_valid,
  output logic [DATA_W-1:0] valM,
  output logic              resp_error,
  input  logic              err_clr,
  output logic              dmem_error
);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_n;
  logic [3:0] cnt;
  logic accept, rd, wr, oob, err_n, enter, pend_err;
  logic [DATA_W-1:0] addr, wdata, rdata, rd_val, data_n, pend_data;
  // Memory is accessed on the acceptance edge; results are parked in pend_* until RESP
  always_comb begin
    rd     = is_rd(icode);
    wr     = is_wr(icode);
    addr   = uses_vala(icode) ? valA : valE;
    wdata  = icode == ICALL ? valP : valA;
    oob    = (rd | wr) && addr >= DATA_W'(DEPTH);
    accept = req_valid & req_ready;
    rd_val = (rd & ~oob) ? rdata : '0;
    data_n = state == S_WAIT ? pend_data : rd_val;
    err_n  = state == S_WAIT ? pend_err : oob;
    enter  = state_n == S_RESP;
  end
  dmem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (accept & wr & ~oob),
    .waddr (addr[AW-1:0]),
    .wdata (wdata),
    .raddr (addr[AW-1:0]),
    .rdata (rdata)
  );
  // cnt holds the number of edges elapsed since acceptance
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= accept ? 4'd1 : state == S_WAIT ? cnt + 4'd1 : '0;
    end
  always_comb
    state_n = state == S_WAIT ? (cnt == 4'(LATENCY - 1) ? S_RESP : S_WAIT)
            : accept ? (LATENCY > 1 ? S_WAIT : S_RESP) : S_IDLE;
  always_comb begin
    req_ready  = state != S_WAIT;
    resp_valid = state == S_RESP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pend_data  <= '0;
      pend_err   <= 1'b0;
      valM       <= '0;
      resp_error <= 1'b0;
      dmem_error <= 1'b0;
    end else begin
      if (accept) begin
        pend_data <= rd_val;
        pend_err  <= oob;
      end
      if (enter) valM <= data_n;
      resp_error <= enter & err_n;
      dmem_error <= (enter & err_n) | (dmem_error & ~err_clr);
    end
endmodule

// File: tb/tb_data_memory_pipe.sv
// tb_data_memory_pipe: directed self-checking bench over LATENCY 1, 3 and 4 instances.
module tb_data_memory_pipe;
  logic clk = 0;
  logic rst_n [3];
  logic req_valid [3];
  logic req_ready [3];
  logic [3:0] icode [3];
  logic [63:0] valA [3];
  logic [63:0] valE [3];
  logic [63:0] valP [3];
  logic resp_valid [3];
  logic [63:0] valM [3];
  logic resp_error [3];
  logic err_clr [3];
  logic dmem_error [3];
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_memory_pipe #(.DATA_W(64), .DEPTH(256), .LATENCY(g == 0 ? 1 : g + 2)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .icode      (icode[g]),
      .valA       (valA[g]),
      .valE       (valE[g]),
      .valP       (valP[g]),
      .resp_valid (resp_valid[g]),
      .valM       (valM[g]),
      .resp_error (resp_error[g]),
      .err_clr    (err_clr[g]),
      .dmem_error (dmem_error[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request on instance d at a negedge, return at the negedge inside its RESP cycle
  task automatic op(input int d, input string tag, input logic [3:0] ic, input logic [63:0] a, e, p,
                    input logic [63:0] exp_m, input logic exp_er);
    int k;
    icode[d] = ic; valA[d] = a; valE[d] = e; valP[d] = p; req_valid[d] = 1;
    k = 0;
    while (!req_ready[d] && k < 20) begin @(negedge clk); k++; end
    @(negedge clk);
    req_valid[d] = 0;
    k = 0;
    while (!resp_valid[d] && k < 20) begin @(negedge clk); k++; end
    chk({tag, "_rv"}, 64'(resp_valid[d]), 1);
    chk({tag, "_lat"}, 64'(k), 64'(d == 0 ? 0 : d + 1));
    chk({tag, "_valM"}, valM[d], exp_m);
    chk({tag, "_err"}, 64'(resp_error[d]), 64'(exp_er));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [8:0] rv_pat, rdy_pat;
    logic seen;
    for (int d = 0; d < 3; d++) begin
      rst_n[d] = 0; req_valid[d] = 0; icode[d] = 0; valA[d] = 0; valE[d] = 0; valP[d] = 0; err_clr[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", 64'(req_ready[d]), 1);
      chk("rst_rv", 64'(resp_valid[d]), 0);
      chk("rst_valM", valM[d], 0);
      chk("rst_rerr", 64'(resp_error[d]), 0);
      chk("rst_derr", 64'(dmem_error[d]), 0);
      rst_n[d] = 1;
    end
    @(negedge clk);
    // LATENCY=1
    op(0, "wr16", 4'h4, 64'hDEAD, 16, 0, 0, 0);
    op(0, "rd16", 4'h5, 0, 16, 0, 64'hDEAD, 0);
    @(negedge clk);
    chk("hold_valM", valM[0], 64'hDEAD);
    chk("idle_rv", 64'(resp_valid[0]), 0);
    op(0, "rd256", 4'h5, 0, 256, 0, 0, 1);
    chk("sticky", 64'(dmem_error[0]), 1);
    op(0, "nop", 4'h1, 1, 2, 3, 0, 0);
    chk("sticky2", 64'(dmem_error[0]), 1);
    err_clr[0] = 1;
    @(negedge clk);
    err_clr[0] = 0;
    chk("clr", 64'(dmem_error[0]), 0);
    op(0, "call", 4'h8, 0, 255, 64'h40, 0, 0);
    op(0, "ret", 4'h9, 255, 0, 0, 64'h40, 0);
    op(0, "wr5", 4'h4, 64'h1234, 5, 0, 0, 0);
    op(0, "rd_big", 4'h5, 0, 64'h1_0000_0005, 0, 0, 1);
    op(0, "push_big", 4'hA, 64'h9999, 64'h1_0000_0005, 0, 0, 1);
    op(0, "pop5", 4'hB, 5, 0, 0, 64'h1234, 0);
    err_clr[0] = 1;
    @(negedge clk);
    chk("clr2", 64'(dmem_error[0]), 0);
    op(0, "set_clr", 4'h5, 0, 300, 0, 0, 1);
    err_clr[0] = 0;
    chk("set_wins", 64'(dmem_error[0]), 1);
    @(negedge clk);
    chk("set_wins2", 64'(dmem_error[0]), 1);
    // LATENCY=3, back-to-back pushq with req_valid held
    icode[1] = 4'hA; valA[1] = 64'h77; valE[1] = 8; req_valid[1] = 1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      rv_pat[8-i] = resp_valid[1];
      rdy_pat[8-i] = req_ready[1];
    end
    req_valid[1] = 0;
    chk("l3_rv_pat", 64'(rv_pat), 64'(9'b001001001));
    chk("l3_rdy_pat", 64'(rdy_pat), 64'(9'b001001001));
    @(negedge clk);
    chk("l3_idle", 64'(resp_valid[1]), 0);
    op(1, "l3_pop8", 4'hB, 8, 0, 0, 64'h77, 0);
    op(1, "l3_oob", 4'h5, 0, 256, 0, 0, 1);
    // LATENCY=4, reset during WAIT
    op(2, "l4_oob", 4'h9, 1000, 0, 0, 0, 1);
    op(2, "l4_wr3", 4'h4, 64'hABC, 3, 0, 0, 0);
    op(2, "l4_rd3", 4'h5, 0, 3, 0, 64'hABC, 0);
    icode[2] = 4'h5; valE[2] = 3; req_valid[2] = 1;
    @(negedge clk);
    req_valid[2] = 0;
    chk("l4_wait_rdy", 64'(req_ready[2]), 0);
    @(negedge clk);
    #2 rst_n[2] = 0;
    #1;
    chk("l4_rst_rdy", 64'(req_ready[2]), 1);
    chk("l4_rst_rv", 64'(resp_valid[2]), 0);
    chk("l4_rst_valM", valM[2], 0);
    chk("l4_rst_rerr", 64'(resp_error[2]), 0);
    chk("l4_rst_derr", 64'(dmem_error[2]), 0);
    @(negedge clk);
    rst_n[2] = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen |= resp_valid[2];
    end
    chk("l4_no_resp", 64'(seen), 0);
    op(2, "l4_rd3b", 4'h5, 0, 3, 0, 64'hABC, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/data_memory_pipe.md
DATA_MEMORY_PIPE -- requirements
Module: data_memory_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 64: data and address width of valA/valE/valP/valM.
REQ-002 SHALL have parameter DEPTH, default 256: number of DATA_W-bit words; word-indexed addressing.
REQ-003 SHALL have parameter LATENCY, default 1, legal 1..15: edges from request acceptance to response.
REQ-004 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, 1: request present this cycle.
REQ-007 SHALL have port req_ready, output, 1: block can accept a request this cycle.
REQ-008 SHALL have port icode, input, 4: Y86 instruction code of the request.
REQ-009 SHALL have ports valA, valE, valP, input, DATA_W: operands from execute stage.
REQ-010 SHALL have port resp_valid, output, 1: one-cycle response pulse.
REQ-011 SHALL have port valM, output, DATA_W: read data, held until next response.
REQ-012 SHALL have port resp_error, output, 1: current response had an out-of-range address.
REQ-013 SHALL have port err_clr, input, 1: synchronous clear of dmem_error.
REQ-014 SHALL have port dmem_error, output, 1: sticky out-of-range flag.

Function
REQ-015 SHALL accept a request on a rising edge where req_valid and req_ready are both high.
REQ-016 SHALL decode: 4 rmmovq write valA@valE; 5 mrmovq read @valE; 8 call write valP@valE; 9 ret read @valA; A pushq write valA@valE; B popq read @valA.
REQ-017 SHALL treat any other icode as no-op: no write, valM=0, resp_error=0, same LATENCY.
REQ-018 SHALL commit writes and sample read data on the acceptance edge, so a later-accepted read sees an earlier write.
REQ-019 SHALL flag an address out of range when address >= DEPTH (full DATA_W compare, no truncation/wrap).
REQ-020 SHALL, for out-of-range: suppress write, return valM=0, pulse resp_error with resp_valid, set dmem_error.
REQ-021 SHALL run FSM IDLE -> (accept) WAIT if LATENCY>1 else RESP; WAIT counts LATENCY-1 edges then RESP; RESP lasts one cycle.
REQ-022 SHALL drive req_ready=1 in IDLE and RESP, 0 in WAIT; accept in RESP goes to WAIT/RESP, else IDLE.
REQ-023 SHALL drive resp_valid=1 only in RESP; sustained throughput one request per LATENCY cycles.
REQ-024 SHALL update valM only on the edge entering RESP.
REQ-025 SHALL give set priority over err_clr when both occur on the same edge.

Reset
REQ-026 SHALL, on rst_n low, asynchronously force state IDLE, counter 0, req_ready=1 after release, resp_valid=0, resp_error=0, valM=0, dmem_error=0.
REQ-027 SHALL abandon any in-flight request on reset (no response issued); a write already committed at acceptance remains.
REQ-028 SHALL NOT reset storage array contents.

Structure
REQ-029 SHALL take icode constants (IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ) and FSM state encodings from shared package y86_pkg.
REQ-030 SHALL instantiate one sub-module dmem_array (DEPTH x DATA_W, one write port, one read port, no reset).

Verification
REQ-031 LATENCY=1: rmmovq valA=0xDEAD, valE=16, then mrmovq valE=16 -> second resp_valid with valM=0xDEAD, resp_error=0.
REQ-032 LATENCY=3: pushq at valE=8, req_valid held high -> req_ready low 2 cycles, resp_valid every 3rd cycle, no lost requests.
REQ-033 mrmovq valE=256 (DEPTH=256) -> valM=0, resp_error=1, dmem_error=1 stays set; err_clr pulse -> dmem_error=0.
REQ-034 call valP=0x40 valE=255, then ret valA=255 -> valM=0x40; address 2^32+5 -> error, no aliasing to 5.
REQ-035 rst_n low during WAIT (LATENCY=4) -> no resp_valid, all outputs reset values, next request served normally.
REQ-036 error-causing response coincident with err_clr -> dmem_error remains 1.
